// File: rtl/uart_cmd_assembler.sv
// Assembles three received UART bytes into a 24-bit command, with an inter-byte
// timeout, and drives single response bytes to the UART transmitter.
module uart_cmd_assembler #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp_data,
  output logic        resp_sent,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done
);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    HOLD    = 2'd3
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  rx_state_t   rx_state_r, rx_state_s;
  tx_state_t   tx_state_r, tx_state_s;
  logic [7:0]  byte0_r, byte1_r;
  logic [15:0] tmo_cnt_r;
  logic [23:0] cmd_r;
  logic        cmd_rdy_r;
  logic        trmt_r;
  logic        resp_sent_r;
  logic [7:0]  tx_data_r;
  logic        capture_s;
  logic        timeout_s;
  logic        tx_start_s;
  logic        tx_finish_s;

  // State registers for both FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r <= WAIT_B0;
      tx_state_r <= TX_IDLE;
    end else begin
      rx_state_r <= rx_state_s;
      tx_state_r <= tx_state_s;
    end
  end

  // Receive next-state: a waiting byte always beats the timeout in the same cycle.
  always_comb begin
    rx_state_s = rx_state_r;
    capture_s  = 1'b0;
    timeout_s  = 1'b0;
    case (rx_state_r)
      WAIT_B0: begin
        if (rx_rdy) begin
          capture_s  = 1'b1;
          rx_state_s = WAIT_B1;
        end else begin
          rx_state_s = WAIT_B0;
        end
      end
      WAIT_B1, WAIT_B2: begin
        if (rx_rdy) begin
          capture_s  = 1'b1;
          rx_state_s = (rx_state_r == WAIT_B1) ? WAIT_B2 : HOLD;
        end else if (tmo_cnt_r == (TIMEOUT - 16'd1)) begin
          timeout_s  = 1'b1;
          rx_state_s = WAIT_B0;
        end else begin
          rx_state_s = rx_state_r;
        end
      end
      HOLD: begin
        if (clr_cmd_rdy) begin
          rx_state_s = WAIT_B0;
        end else begin
          rx_state_s = HOLD;
        end
      end
      default: begin
        rx_state_s = WAIT_B0;
      end
    endcase
  end

  // Transmit next-state; send_resp is only looked at while idle.
  always_comb begin
    tx_state_s  = tx_state_r;
    tx_start_s  = 1'b0;
    tx_finish_s = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if (send_resp) begin
          tx_start_s = 1'b1;
          tx_state_s = TX_BUSY;
        end else begin
          tx_state_s = TX_IDLE;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          tx_finish_s = 1'b1;
          tx_state_s  = TX_IDLE;
        end else begin
          tx_state_s  = TX_BUSY;
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
      end
    endcase
  end

  // Byte acknowledge must stay low throughout reset even if rx_rdy is high.
  assign clr_rx_rdy = capture_s & rst_n;

  // Shadow bytes, inter-byte counter and the published command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte0_r   <= 8'h00;
      byte1_r   <= 8'h00;
      tmo_cnt_r <= 16'd0;
      cmd_r     <= 24'h000000;
      cmd_rdy_r <= 1'b0;
    end else begin
      if (capture_s && (rx_state_r == WAIT_B0)) begin
        byte0_r <= rx_data;
      end else if (timeout_s) begin
        byte0_r <= 8'h00;
      end else begin
        byte0_r <= byte0_r;
      end

      if (capture_s && (rx_state_r == WAIT_B1)) begin
        byte1_r <= rx_data;
      end else if (timeout_s) begin
        byte1_r <= 8'h00;
      end else begin
        byte1_r <= byte1_r;
      end

      if (capture_s || timeout_s || (rx_state_r == WAIT_B0) || (rx_state_r == HOLD)) begin
        tmo_cnt_r <= 16'd0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + 16'd1;
      end

      if (capture_s && (rx_state_r == WAIT_B2)) begin
        cmd_r     <= {byte0_r, byte1_r, rx_data};
        cmd_rdy_r <= 1'b1;
      end else if ((rx_state_r == HOLD) && clr_cmd_rdy) begin
        cmd_r     <= cmd_r;
        cmd_rdy_r <= 1'b0;
      end else begin
        cmd_r     <= cmd_r;
        cmd_rdy_r <= cmd_rdy_r;
      end
    end
  end

  // Transmit datapath: trmt and resp_sent are single-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trmt_r      <= 1'b0;
      tx_data_r   <= 8'h00;
      resp_sent_r <= 1'b0;
    end else begin
      trmt_r      <= tx_start_s;
      resp_sent_r <= tx_finish_s;
      if (tx_start_s) begin
        tx_data_r <= resp_data;
      end else begin
        tx_data_r <= tx_data_r;
      end
    end
  end

  assign cmd       = cmd_r;
  assign cmd_rdy   = cmd_rdy_r;
  assign trmt      = trmt_r;
  assign tx_data   = tx_data_r;
  assign resp_sent = resp_sent_r;

endmodule
